nibbler_core_p: RTL and testbench
=================================

Name: nibbler_core_p

Overview:
Parametrised successor to the 4-bit two-phase uP core. Fetch/execute accumulator machine with generic data width, program-address width, and multiple input/output ports selectable per instruction. External program ROM (combinational read) and external data RAM. Sits in the uP top level in place of the fixed-width core; flag and observation ports are kept for bench visibility.

Parameters:
DATA_W, 4, accumulator / data / immediate width (>=2)
ADDR_W, 12, program counter and RAM address width (>=DATA_W)
N_IN, 2, number of input ports (power of 2, 1..16)
N_OUT, 2, number of output ports (power of 2, 1..16)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PUSHBUTTONS  in  N_IN*DATA_W  input ports; port k = bits [k*DATA_W +: DATA_W]
PROGRAM_BYTE  in  4+ADDR_W  instruction word at PC: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand
PC  out  ADDR_W  program counter
ADDRESS_RAM  out  ADDR_W  RAM address = latched operand
DATA_BUS  in  DATA_W  RAM read data (combinational)
RAM_WDATA  out  DATA_W  = ACCU
RAM_WE  out  1  write strobe
FF_OUT  out  N_OUT*DATA_W  registered output ports
ACCU  out  DATA_W  accumulator
C_FLAG, Z_FLAG  out  1 each  carry and zero flags
PHASE  out  1  0 = fetch, 1 = execute
INSTR  out  4  latched opcode
OPERAND  out  ADDR_W  latched operand

Behaviour:
- Reset (reset=0, async): PC=0, PHASE=0, INSTR=0, OPERAND=0, ACCU=0, C=Z=0, all FF_OUT=0, RAM_WE=0. Reset asserted mid-execute aborts the instruction; no partial state update.
- Two-state FSM, alternating every clock: FETCH (PHASE=0): IR <= PROGRAM_BYTE, PC <= PC+1 (wraps 2^ADDR_W-1 -> 0). EXECUTE (PHASE=1): perform INSTR; return to FETCH. Each instruction takes 2 clocks.
- imm = OPERAND[DATA_W-1:0]; M = DATA_BUS; target = OPERAND; in-port = OPERAND mod N_IN; out-port = OPERAND mod N_OUT.
- Opcodes: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NORI, F NORM.
- ADD: {C,ACCU} <= ACCU+x (DATA_W+1 bits); Z <= (sum[DATA_W-1:0]==0).
- NOR: ACCU <= ~(ACCU|x); Z updated; C unchanged.
- CMP: ACCU unchanged; C <= (ACCU >= x) (no borrow); Z <= (ACCU==x).
- LIT, IN, LD load ACCU; flags unchanged. OUT writes ACCU to the selected FF_OUT port; other ports hold.
- ST: RAM_WE=1 only during the EXECUTE cycle of ST (combinational from state+INSTR); 0 otherwise.
- Jumps load PC <= target in EXECUTE when the condition holds (JC: C=1, JNC: C=0, JZ: Z=1, JNZ: Z=0, JMP: always); otherwise PC keeps the incremented value.
- A jump to the current address yields a 2-cycle self-loop; this is legal.

Optional Feature:
NIBBLER_BRK_EN: adds inputs BRK_ADDR (ADDR_W), BRK_ARM (1), STEP (1) and output HALTED (1).
- When in FETCH with BRK_ARM=1 and PC==BRK_ADDR, the core enters HALT: PC and IR are not updated, HALTED=1, and no state changes.
- A one-cycle STEP=1 releases exactly one instruction (fetch + execute). The core then re-halts only if it still matches.
- Reset clears HALTED.
- Without the macro, these ports and the HALT state do not exist.

Test Plan:
- Reset pulse, then LIT 9 -> after 2 clocks ACCU=4'b1001, PC=1, C=Z=0.
- PUSHBUTTONS port1=4'b0110; IN 1; OUT 1 -> ACCU=4'b0110, FF_OUT[7:4]=4'b0110, FF_OUT[3:0]=0.
- ACCU=9: ADDI 6 -> ACCU=F, C=0; then ADDI 1 -> ACCU=0, C=1, Z=1.
- LIT 0; NORI 5 -> ACCU=4'b1010, Z=0; NORI F -> ACCU=0, Z=1. Then CMPI 0 -> Z=1, C=1, ACCU unchanged.
- JMP 13 -> PC=13 at next FETCH. With C=1, JC 19 -> PC=19. With Z=0, JZ 32 falls through (PC=+1) and JNZ 10 -> PC=10. PC=0xFFF plain instruction -> PC wraps to 0.
- ST to address 5 -> RAM_WE high exactly one cycle (EXECUTE). Assert reset during EXECUTE of ADDI -> ACCU, flags and PC all 0 immediately.

Source files
------------

// File: rtl/nibbler_core_p.sv
// nibbler_core_p: parametrised two-phase (fetch / execute) accumulator core.
// Program ROM and data RAM are external with combinational reads.
// Optional breakpoint / single-step support is compiled in when the macro
// NIBBLER_BRK_EN is defined (adds BRK_ADDR, BRK_ARM, STEP and HALTED).
module nibbler_core_p #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN*DATA_W-1:0]    PUSHBUTTONS,
  input  logic [ADDR_W+3:0]         PROGRAM_BYTE,
  output logic [ADDR_W-1:0]         PC,
  output logic [ADDR_W-1:0]         ADDRESS_RAM,
  input  logic [DATA_W-1:0]         DATA_BUS,
  output logic [DATA_W-1:0]         RAM_WDATA,
  output logic                      RAM_WE,
  output logic [N_OUT*DATA_W-1:0]   FF_OUT,
  output logic [DATA_W-1:0]         ACCU,
  output logic                      C_FLAG,
  output logic                      Z_FLAG,
  output logic                      PHASE,
  output logic [3:0]                INSTR,
  output logic [ADDR_W-1:0]         OPERAND
`ifdef NIBBLER_BRK_EN
  ,
  input  logic [ADDR_W-1:0]         BRK_ADDR,
  input  logic                      BRK_ARM,
  input  logic                      STEP,
  output logic                      HALTED
`endif
);

  // Opcode map
  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_CMPI = 4'h2;
  localparam logic [3:0] OP_CMPM = 4'h3;
  localparam logic [3:0] OP_LIT  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_ADDM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_NORI = 4'hE;
  localparam logic [3:0] OP_NORM = 4'hF;

  // Port-select widths; a single port still needs a 1-bit selector
  localparam int IN_SEL_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OUT_SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

`ifdef NIBBLER_BRK_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;
`else
  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;
`endif

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic [3:0]                 instr_q, instr_d;
  logic [ADDR_W-1:0]          operand_q, operand_d;
  logic [DATA_W-1:0]          accu_q, accu_d;
  logic                       c_q, c_d;
  logic                       z_q, z_d;
  logic [N_OUT*DATA_W-1:0]    ff_out_q, ff_out_d;

  logic [ADDR_W-1:0]          pc_inc_s;
  logic                       fetch_go_s;
  logic [DATA_W-1:0]          imm_s;
  logic [DATA_W-1:0]          alu_x_s;
  logic [DATA_W:0]            sum_s;
  logic [DATA_W-1:0]          nor_s;
  logic [DATA_W-1:0]          in_data_s;
  logic [IN_SEL_W-1:0]        in_sel_s;
  logic [OUT_SEL_W-1:0]       out_sel_s;

  assign pc_inc_s  = pc_q + ADDR_W'(1);
  assign imm_s     = operand_q[DATA_W-1:0];
  // Port numbers are the operand modulo the (power-of-two) port count
  assign in_sel_s  = IN_SEL_W'(operand_q & ADDR_W'(N_IN - 1));
  assign out_sel_s = OUT_SEL_W'(operand_q & ADDR_W'(N_OUT - 1));

  // ALU operand: odd opcodes of the CMP/ADD/NOR pairs take RAM data, even ones the immediate
  always_comb begin
    if (instr_q[0]) begin
      alu_x_s = DATA_BUS;
    end else begin
      alu_x_s = imm_s;
    end
  end

  assign sum_s = {1'b0, accu_q} + {1'b0, alu_x_s};
  assign nor_s = ~(accu_q | alu_x_s);

  // Input-port multiplexer
  always_comb begin
    in_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel_s == IN_SEL_W'(k)) begin
        in_data_s = PUSHBUTTONS[k*DATA_W +: DATA_W];
      end else begin
        in_data_s = in_data_s;
      end
    end
  end

  // Decide whether an instruction fetch is allowed this cycle
  always_comb begin
    fetch_go_s = 1'b0;
    case (state_q)
      S_FETCH: begin
`ifdef NIBBLER_BRK_EN
        if (BRK_ARM && (pc_q == BRK_ADDR)) begin
          fetch_go_s = 1'b0;
        end else begin
          fetch_go_s = 1'b1;
        end
`else
        fetch_go_s = 1'b1;
`endif
      end
`ifdef NIBBLER_BRK_EN
      S_HALT: begin
        if (STEP) begin
          fetch_go_s = 1'b1;
        end else begin
          fetch_go_s = 1'b0;
        end
      end
`endif
      default: fetch_go_s = 1'b0;
    endcase
  end

  // Next-state logic: fetch latches the instruction, execute applies it
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    accu_d    = accu_q;
    c_d       = c_q;
    z_d       = z_q;
    ff_out_d  = ff_out_q;
    case (state_q)
      S_EXEC: begin
        state_d = S_FETCH;
        case (instr_q)
          OP_JC: begin
            if (c_q) begin
              pc_d = operand_q;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JNC: begin
            if (!c_q) begin
              pc_d = operand_q;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JZ: begin
            if (z_q) begin
              pc_d = operand_q;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JNZ: begin
            if (!z_q) begin
              pc_d = operand_q;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JMP: pc_d = operand_q;
          OP_CMPI, OP_CMPM: begin
            c_d = (accu_q >= alu_x_s);
            z_d = (accu_q == alu_x_s);
          end
          OP_LIT: accu_d = imm_s;
          OP_IN:  accu_d = in_data_s;
          OP_LD:  accu_d = DATA_BUS;
          OP_ST:  accu_d = accu_q;
          OP_ADDI, OP_ADDM: begin
            accu_d = sum_s[DATA_W-1:0];
            c_d    = sum_s[DATA_W];
            z_d    = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
          end
          OP_OUT: begin
            for (int k = 0; k < N_OUT; k++) begin
              if (out_sel_s == OUT_SEL_W'(k)) begin
                ff_out_d[k*DATA_W +: DATA_W] = accu_q;
              end else begin
                ff_out_d[k*DATA_W +: DATA_W] = ff_out_q[k*DATA_W +: DATA_W];
              end
            end
          end
          OP_NORI, OP_NORM: begin
            accu_d = nor_s;
            z_d    = (nor_s == {DATA_W{1'b0}});
          end
          default: accu_d = accu_q;
        endcase
      end
      default: begin
        if (fetch_go_s) begin
          state_d   = S_EXEC;
          instr_d   = PROGRAM_BYTE[ADDR_W+3:ADDR_W];
          operand_d = PROGRAM_BYTE[ADDR_W-1:0];
          pc_d      = pc_inc_s;
        end else begin
`ifdef NIBBLER_BRK_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
    endcase
  end

  // Architectural state registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= {ADDR_W{1'b0}};
      instr_q   <= 4'h0;
      operand_q <= {ADDR_W{1'b0}};
      accu_q    <= {DATA_W{1'b0}};
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      ff_out_q  <= {(N_OUT*DATA_W){1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      accu_q    <= accu_d;
      c_q       <= c_d;
      z_q       <= z_d;
      ff_out_q  <= ff_out_d;
    end
  end

  assign PC          = pc_q;
  assign ADDRESS_RAM = operand_q;
  assign RAM_WDATA   = accu_q;
  // Write strobe exists only while a store is executing
  assign RAM_WE      = (state_q == S_EXEC) && (instr_q == OP_ST);
  assign FF_OUT      = ff_out_q;
  assign ACCU        = accu_q;
  assign C_FLAG      = c_q;
  assign Z_FLAG      = z_q;
  assign PHASE       = (state_q == S_EXEC);
  assign INSTR       = instr_q;
  assign OPERAND     = operand_q;
`ifdef NIBBLER_BRK_EN
  assign HALTED      = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_nibbler_core_p.sv
// Self-checking bench for nibbler_core_p: directed program with hand-computed
// expectations, then random programs checked every cycle against an
// instruction-level reference model.
module tb_nibbler_core_p;
  localparam int DW = 4;
  localparam int AW = 12;
  localparam int NI = 2;
  localparam int NO = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI*DW-1:0] PUSHBUTTONS;
  logic [AW+3:0]    PROGRAM_BYTE;
  logic [AW-1:0]    PC, ADDRESS_RAM, OPERAND;
  logic [DW-1:0]    DATA_BUS, RAM_WDATA, ACCU;
  logic             RAM_WE, C_FLAG, Z_FLAG, PHASE;
  logic [NO*DW-1:0] FF_OUT;
  logic [3:0]       INSTR;
`ifdef NIBBLER_BRK_EN
  logic HALTED;
`endif

  logic [15:0] rom [0:4095];
  logic [3:0]  dut_ram [0:4095];

  // reference model state
  logic [11:0] m_pc, m_op;
  logic        m_ph, m_c, m_z;
  logic [3:0]  m_ir, m_acc;
  logic [3:0]  m_out [0:1];
  logic [3:0]  m_ram [0:4095];

  int errors = 0;
  int checks = 0;

  assign PROGRAM_BYTE = rom[PC];
  assign DATA_BUS     = dut_ram[ADDRESS_RAM];

  always #5 clk = ~clk;

  nibbler_core_p #(.DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .reset(reset), .PUSHBUTTONS(PUSHBUTTONS), .PROGRAM_BYTE(PROGRAM_BYTE),
    .PC(PC), .ADDRESS_RAM(ADDRESS_RAM), .DATA_BUS(DATA_BUS), .RAM_WDATA(RAM_WDATA),
    .RAM_WE(RAM_WE), .FF_OUT(FF_OUT), .ACCU(ACCU), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .PHASE(PHASE), .INSTR(INSTR), .OPERAND(OPERAND)
`ifdef NIBBLER_BRK_EN
    , .BRK_ADDR(12'h000), .BRK_ARM(1'b0), .STEP(1'b0), .HALTED(HALTED)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc",        32'(PC),          32'(m_pc));
    chk("accu",      32'(ACCU),        32'(m_acc));
    chk("c_flag",    32'(C_FLAG),      32'(m_c));
    chk("z_flag",    32'(Z_FLAG),      32'(m_z));
    chk("phase",     32'(PHASE),       32'(m_ph));
    chk("instr",     32'(INSTR),       32'(m_ir));
    chk("operand",   32'(OPERAND),     32'(m_op));
    chk("ff_out",    32'(FF_OUT),      32'({m_out[1], m_out[0]}));
    chk("ram_we",    32'(RAM_WE),      32'(m_ph && (m_ir == 4'h7)));
    chk("ram_addr",  32'(ADDRESS_RAM), 32'(m_op));
    chk("ram_wdata", 32'(RAM_WDATA),   32'(m_acc));
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_op = 12'h000; m_ph = 1'b0; m_c = 1'b0; m_z = 1'b0;
    m_ir = 4'h0; m_acc = 4'h0; m_out[0] = 4'h0; m_out[1] = 4'h0;
  endtask

  // One clock: model computes the next state at instruction level, DUT clocks,
  // then outputs are compared at the falling edge.
  task automatic tick();
    logic [11:0] n_pc, n_op;
    logic        n_ph, n_c, n_z, st, w_en;
    logic [3:0]  n_ir, n_acc, st_d, w_d, imm, mem;
    logic [3:0]  n_out [0:1];
    logic [11:0] st_a, w_a;
    int          x, s;
    w_en = RAM_WE; w_a = ADDRESS_RAM; w_d = RAM_WDATA;
    n_pc = m_pc; n_op = m_op; n_ph = m_ph; n_c = m_c; n_z = m_z;
    n_ir = m_ir; n_acc = m_acc; n_out = m_out;
    st = 1'b0; st_a = m_op; st_d = m_acc;
    imm = m_op[3:0];
    mem = m_ram[m_op];
    x = (m_ir == 4'h3 || m_ir == 4'hB || m_ir == 4'hF) ? int'(mem) : int'(imm);
    if (!m_ph) begin
      n_ir = rom[m_pc][15:12];
      n_op = rom[m_pc][11:0];
      n_pc = m_pc + 12'd1;
      n_ph = 1'b1;
    end else begin
      n_ph = 1'b0;
      case (m_ir)
        4'h0: if (m_c)  n_pc = m_op;
        4'h1: if (!m_c) n_pc = m_op;
        4'h8: if (m_z)  n_pc = m_op;
        4'h9: if (!m_z) n_pc = m_op;
        4'hC: n_pc = m_op;
        4'h2, 4'h3: begin
          n_c = (int'(m_acc) >= x);
          n_z = (int'(m_acc) == x);
        end
        4'h4: n_acc = imm;
        4'h5: n_acc = 4'(PUSHBUTTONS >> (4 * (m_op % 12'd2)));
        4'h6: n_acc = mem;
        4'h7: st = 1'b1;
        4'hA, 4'hB: begin
          s = int'(m_acc) + x;
          n_acc = 4'(s % 16);
          n_c = (s > 15);
          n_z = ((s % 16) == 0);
        end
        4'hD: n_out[m_op % 12'd2] = m_acc;
        default: begin
          n_acc = ~(m_acc | 4'(x));
          n_z = (n_acc == 4'h0);
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_op = n_op; m_ph = n_ph; m_c = n_c; m_z = n_z;
    m_ir = n_ir; m_acc = n_acc; m_out = n_out;
    if (st) m_ram[st_a] = st_d;
    if (w_en) dut_ram[w_a] = w_d;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pull reset now (between edges), check immediately, release at the next falling edge
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1;
    model_reset();
    chk({nm, "_pc"},   32'(PC),     32'h0);
    chk({nm, "_accu"}, 32'(ACCU),   32'h0);
    chk({nm, "_c"},    32'(C_FLAG), 32'h0);
    chk({nm, "_z"},    32'(Z_FLAG), 32'h0);
    chk({nm, "_ff"},   32'(FF_OUT), 32'h0);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b0;
    PUSHBUTTONS = 8'h63;
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 16'h4000;
      dut_ram[i] = 4'(i * 7 + 3);
      m_ram[i] = 4'(i * 7 + 3);
    end
    // directed program
    rom[12'h000] = 16'h4009;  // LIT 9
    rom[12'h001] = 16'h5001;  // IN 1
    rom[12'h002] = 16'hD001;  // OUT 1
    rom[12'h003] = 16'h4009;  // LIT 9
    rom[12'h004] = 16'hA006;  // ADDI 6
    rom[12'h005] = 16'hA001;  // ADDI 1
    rom[12'h006] = 16'h4000;  // LIT 0
    rom[12'h007] = 16'hE005;  // NORI 5
    rom[12'h008] = 16'hE00F;  // NORI F
    rom[12'h009] = 16'h2000;  // CMPI 0
    rom[12'h00A] = 16'hC013;  // JMP 13
    rom[12'h013] = 16'h0019;  // JC 19
    rom[12'h019] = 16'hA001;  // ADDI 1
    rom[12'h01A] = 16'h8032;  // JZ 32
    rom[12'h01B] = 16'h9010;  // JNZ 10
    rom[12'h010] = 16'h7005;  // ST 5
    rom[12'h011] = 16'hCFFF;  // JMP FFF
    rom[12'hFFF] = 16'h4007;  // LIT 7
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pc",    32'(PC),     32'h0);
    chk("rst_phase", 32'(PHASE),  32'h0);
    chk("rst_we",    32'(RAM_WE), 32'h0);
    compare_all();

    run(2);  chk("lit9_accu", 32'(ACCU), 32'h9); chk("lit9_pc", 32'(PC), 32'h1);
             chk("lit9_c", 32'(C_FLAG), 32'h0); chk("lit9_z", 32'(Z_FLAG), 32'h0);
    run(4);  chk("in_accu", 32'(ACCU), 32'h6); chk("out_ff", 32'(FF_OUT), 32'h60);
    run(4);  chk("addi6_accu", 32'(ACCU), 32'hF); chk("addi6_c", 32'(C_FLAG), 32'h0);
    run(2);  chk("addi1_accu", 32'(ACCU), 32'h0); chk("addi1_c", 32'(C_FLAG), 32'h1);
             chk("addi1_z", 32'(Z_FLAG), 32'h1);
    run(4);  chk("nori5_accu", 32'(ACCU), 32'hA); chk("nori5_z", 32'(Z_FLAG), 32'h0);
             chk("nori5_c", 32'(C_FLAG), 32'h1);
    run(2);  chk("norif_accu", 32'(ACCU), 32'h0); chk("norif_z", 32'(Z_FLAG), 32'h1);
    run(2);  chk("cmpi_z", 32'(Z_FLAG), 32'h1); chk("cmpi_c", 32'(C_FLAG), 32'h1);
             chk("cmpi_accu", 32'(ACCU), 32'h0);
    run(2);  chk("jmp_pc", 32'(PC), 32'h013);
    run(2);  chk("jc_pc", 32'(PC), 32'h019);
    run(2);  chk("addi_z0", 32'(Z_FLAG), 32'h0);
    run(2);  chk("jz_fall_pc", 32'(PC), 32'h01B);
    run(2);  chk("jnz_pc", 32'(PC), 32'h010);
             chk("st_we_fetch", 32'(RAM_WE), 32'h0);
    run(1);  chk("st_we_exec", 32'(RAM_WE), 32'h1);
    run(1);  chk("st_we_after", 32'(RAM_WE), 32'h0); chk("st_ram5", 32'(dut_ram[5]), 32'h1);
    run(2);  chk("jmp_fff_pc", 32'(PC), 32'hFFF);
    run(2);  chk("wrap_pc", 32'(PC), 32'h000); chk("wrap_accu", 32'(ACCU), 32'h7);
    run(8);
    run(1);  chk("addi_exec_phase", 32'(PHASE), 32'h1);
    do_reset("rst_exec");

    // random programs against the reference model
    reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      PUSHBUTTONS = 8'($urandom);
      if (cyc == 1501) do_reset("rst_rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
